t05_status_shift_driver: RTL and testbench



---
 rtl/t05_pkg.sv | 30 +++
 rtl/t05_status_shift_driver_if.sv | 37 +++
 rtl/t05_tick_counter.sv | 37 +++
 rtl/t05_status_shift_driver.sv | 155 +++++++++++++++
 tb/tb_t05_status_shift_driver.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/t05_pkg.sv
// Package shared by the status shift driver slice.
// Contents: the FSM state encoding, frame geometry constants and a helper
// that assembles the 8-bit LED frame from the blink bit and the status code.
package t05_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LATCH    = 3'd4
  } state_t;

  localparam int FRAME_W    = 8;
  localparam int CODE_W     = 6;
  localparam int MARKER_BIT = 6;
  localparam int BLINK_BIT  = 7;

  // Frame layout: {blink bit, constant 1 marker, code[5:0]}.
  function automatic logic [FRAME_W-1:0] make_frame(input logic              blink_bit,
                                                    input logic [CODE_W-1:0] code);
    logic [FRAME_W-1:0] f;
    f                 = '0;
    f[CODE_W-1:0]     = code;
    f[MARKER_BIT]     = 1'b1;
    f[BLINK_BIT]      = blink_bit;
    return f;
  endfunction

endpackage

// File: rtl/t05_status_shift_driver_if.sv
// Interface bundling the status input side and the 74HC595 output side of
// the status shift driver.
//   status_code : 6-bit code from display control (producer -> driver)
//   blink_en    : enable blinking of frame bit 7
//   refresh     : single-cycle pulse requesting one retransmission
//   sr_data     : serial data, MSB first
//   sr_clk      : shift clock, the external register samples on its rising edge
//   sr_latch    : storage-register latch pulse, active high
//   busy        : high for the whole LOAD..LATCH span of a frame
//
// Protocol: there is no valid/ready pair. status_code and blink_en are level
// inputs sampled every cycle; refresh is a one-cycle strobe that is always
// accepted (it is remembered until the next frame load, so it may arrive at
// any time, busy or not). The driver never waits on the shift register: each
// sr_clk phase and the latch pulse last a fixed CLK_DIV cycles.
interface t05_status_shift_driver_if;
  import t05_pkg::*;

  logic [CODE_W-1:0] status_code;
  logic              blink_en;
  logic              refresh;
  logic              sr_data;
  logic              sr_clk;
  logic              sr_latch;
  logic              busy;

  modport slave (
    input  status_code, blink_en, refresh,
    output sr_data, sr_clk, sr_latch, busy
  );

  modport master (
    output status_code, blink_en, refresh,
    input  sr_data, sr_clk, sr_latch, busy
  );

endinterface

// File: rtl/t05_tick_counter.sv
// Reloadable down-counter used for both bit timing and blink timing.
// Ports:
//   clk, nrst : clock, asynchronous active-low reset
//   reload    : synchronous reload to N-1 (wins over en)
//   en        : count one step; at 0 it wraps back to N-1
//   done      : counter is at 0 (last cycle of an N-cycle period)
// Counting down from N-1 is the same period as counting up 0..N-1; the reset
// value N-1 corresponds to "no cycles elapsed".
module t05_tick_counter #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic reload,
  input  logic en,
  output logic done
);

  localparam int          W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] TOP = W'(N - 1);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= TOP;
    end else if (reload) begin
      cnt <= TOP;
    end else if (en) begin
      cnt <= (cnt == '0) ? TOP : cnt - ONE;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/t05_status_shift_driver.sv
// Status shift driver: serializes the 6-bit status code into an 8-bit frame
// and shifts it into an external 74HC595-style register, then pulses latch.
// A frame is sent only after reset, when the code differs from the last one
// sent, on a refresh request, or when the visible blink bit changes.
// Ports:
//   clk       : system clock
//   nrst      : asynchronous active-low reset
//   bus       : slave side of t05_status_shift_driver_if
//   dbg_state : current FSM state, for observation only
module t05_status_shift_driver
  import t05_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned BLINK_CYCLES = 1_000_000
) (
  input  logic                           clk,
  input  logic                           nrst,
  t05_status_shift_driver_if.slave       bus,
  output state_t                         dbg_state
);

  state_t             state;
  logic [FRAME_W-1:0] shreg;
  logic [2:0]         bit_cnt;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  last_code;
  logic               sent_valid;
  logic               blink_phase;
  logic               blink_pend;
  logic               refresh_pend;

  logic               div_done;
  logic               div_reload;
  logic               blink_done;
  logic               blink_wrap;
  logic               trigger;
  logic [FRAME_W-1:0] frame;

  // The divider is reloaded while in the untimed states and whenever a timed
  // state expires, so every timed state starts with a full CLK_DIV count.
  assign div_reload = (state == IDLE) || (state == LOAD) || div_done;

  t05_tick_counter #(.N(CLK_DIV)) u_div (
    .clk    (clk),
    .nrst   (nrst),
    .reload (div_reload),
    .en     (1'b1),
    .done   (div_done)
  );

  // Blink counter is held at its start value while blinking is disabled.
  t05_tick_counter #(.N(BLINK_CYCLES)) u_blink (
    .clk    (clk),
    .nrst   (nrst),
    .reload (!bus.blink_en),
    .en     (bus.blink_en),
    .done   (blink_done)
  );

  assign blink_wrap = bus.blink_en && blink_done;

  assign trigger = !sent_valid || (bus.status_code != last_code) ||
                   blink_pend || refresh_pend;

  assign frame = make_frame(bus.blink_en & blink_phase, bus.status_code);

  // Pending requests. A new request in the LOAD cycle wins over the clear, so
  // it is not swallowed by the frame that is being captured right now.
  // Disabling blink while the phase is 1 also changes the visible bit 7, so it
  // requests one frame to put the LEDs back to the steady pattern.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      blink_phase  <= 1'b0;
      blink_pend   <= 1'b0;
      refresh_pend <= 1'b0;
    end else begin
      if (!bus.blink_en)   blink_phase <= 1'b0;
      else if (blink_wrap) blink_phase <= ~blink_phase;

      if (blink_wrap || (!bus.blink_en && blink_phase)) blink_pend <= 1'b1;
      else if (state == LOAD)                          blink_pend <= 1'b0;

      if (bus.refresh)        refresh_pend <= 1'b1;
      else if (state == LOAD) refresh_pend <= 1'b0;
    end
  end

  // Outputs are registered alongside the state, so they always carry the
  // values belonging to the state being entered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      code_q       <= '0;
      last_code    <= '0;
      sent_valid   <= 1'b0;
      bus.sr_data  <= 1'b0;
      bus.sr_clk   <= 1'b0;
      bus.sr_latch <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state    <= LOAD;
            bus.busy <= 1'b1;
          end
        end
        LOAD: begin
          shreg       <= frame;
          code_q      <= bus.status_code;
          bit_cnt     <= '0;
          bus.sr_clk  <= 1'b0;
          bus.sr_data <= frame[FRAME_W-1];
          state       <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (div_done) begin
            bus.sr_clk <= 1'b1;
            state      <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (div_done) begin
            bus.sr_clk <= 1'b0;
            if (bit_cnt == 3'd7) begin
              bus.sr_data  <= 1'b0;
              bus.sr_latch <= 1'b1;
              state        <= LATCH;
            end else begin
              shreg       <= shreg << 1;
              bit_cnt     <= bit_cnt + 3'd1;
              bus.sr_data <= shreg[FRAME_W-2];
              state       <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          if (div_done) begin
            bus.sr_latch <= 1'b0;
            bus.busy     <= 1'b0;
            last_code    <= code_q;
            sent_valid   <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_t05_status_shift_driver.sv
// Directed bench for t05_status_shift_driver (CLK_DIV=4, BLINK_CYCLES=200).
// A monitor decodes frames off the sr_* pins; expected frames are pushed by
// the stimulus into exp_q and compared against the decoded frames.
module tb_t05_status_shift_driver;
  import t05_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   nrst = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  t05_status_shift_driver_if bus ();

  t05_status_shift_driver #(.CLK_DIV(4), .BLINK_CYCLES(200)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check({tag, "_frame"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- pin monitor ----------------
  logic [7:0] sh;
  int bit_n, bits_at_latch;
  int latch_run, last_latch, busy_run, last_busy, gap_run, last_gap;
  int stab_err = 0;
  logic prev_clk, prev_data, prev_latch, prev_busy;

  always @(negedge clk) begin
    if (!nrst) begin
      sh <= '0; bit_n <= 0;
      latch_run <= 0; busy_run <= 0; gap_run <= 0;
      prev_clk <= 1'b0; prev_data <= 1'b0; prev_latch <= 1'b0; prev_busy <= 1'b0;
    end else begin
      if (bus.sr_clk && !prev_clk) begin
        sh    <= {sh[6:0], bus.sr_data};
        bit_n <= bit_n + 1;
      end
      if (bus.sr_clk && prev_clk && (bus.sr_data !== prev_data)) stab_err <= stab_err + 1;
      if (bus.sr_latch && !prev_latch) begin
        got_q.push_back(sh);
        bits_at_latch <= bit_n;
        bit_n         <= 0;
      end
      if (bus.sr_latch) latch_run <= latch_run + 1;
      else if (prev_latch) begin last_latch <= latch_run; latch_run <= 0; end
      if (bus.busy) begin
        busy_run <= busy_run + 1;
        if (!prev_busy) begin last_gap <= gap_run; gap_run <= 0; end
      end else begin
        gap_run <= gap_run + 1;
        if (prev_busy) begin last_busy <= busy_run; busy_run <= 0; end
      end
      prev_clk   <= bus.sr_clk;
      prev_data  <= bus.sr_data;
      prev_latch <= bus.sr_latch;
      prev_busy  <= bus.busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_refresh();
    @(negedge clk); bus.refresh = 1'b1;
    @(negedge clk); bus.refresh = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int n, input int max);
    int i = 0;
    while (got_q.size() < n && i < max) begin @(negedge clk); i++; end
    check({tag, "_arrive"}, (got_q.size() >= n), 1);
  endtask

  task automatic wait_quiet(input string tag, input int max);
    int q = 0;
    int i = 0;
    while (q < 12 && i < max) begin
      @(negedge clk); i++;
      if (bus.busy) q = 0; else q++;
    end
    check({tag, "_quiet"}, (q >= 12), 1);
  endtask

  task automatic wait_bits(input string tag, input int n, input int max);
    int i = 0;
    while (!(bus.busy && bit_n == n) && i < max) begin @(negedge clk); i++; end
    check({tag, "_bit"}, bit_n, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.status_code = 6'h05;
    bus.blink_en    = 1'b0;
    bus.refresh     = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_sr_data", bus.sr_data, 0);
    check("rst_sr_clk", bus.sr_clk, 0);
    check("rst_sr_latch", bus.sr_latch, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // T1: first frame after reset release
    nrst = 1'b1;
    @(posedge clk); #1;
    check("t1_load_state", 32'(dbg_state), 32'(LOAD));
    check("t1_load_busy", bus.busy, 1);
    exp_q.push_back(8'h45);
    wait_frames("t1", 1, 200);
    wait_quiet("t1", 300);
    check_frames("t1");
    check("t1_bits", bits_at_latch, 8);
    check("t1_latch_len", last_latch, 4);
    check("t1_busy_len", last_busy, 69);
    repeat (300) @(negedge clk);
    check("t1_no_traffic", got_q.size(), 0);

    // T2: code change while idle
    @(negedge clk); bus.status_code = 6'h12;
    exp_q.push_back(8'h52);
    wait_frames("t2", 1, 200);
    wait_quiet("t2", 300);
    check_frames("t2");
    check("t2_data_stable", stab_err, 0);

    // T3: code change mid-frame, then change-and-revert mid-frame
    pulse_refresh();
    wait_bits("t3", 3, 200);
    bus.status_code = 6'h3F;
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h7F);
    wait_frames("t3", 2, 400);
    wait_quiet("t3", 300);
    check_frames("t3");
    check("t3_gap", last_gap, 1);

    pulse_refresh();
    wait_bits("t3r", 2, 200);
    bus.status_code = 6'h00;
    wait_bits("t3r", 5, 200);
    bus.status_code = 6'h3F;
    exp_q.push_back(8'h7F);
    wait_frames("t3r", 1, 200);
    wait_quiet("t3r", 300);
    repeat (200) @(negedge clk);
    check_frames("t3r");

    // T4: blinking, then disable
    @(negedge clk);
    bus.status_code = 6'h07;
    bus.blink_en    = 1'b1;
    exp_q.push_back(8'h47);
    exp_q.push_back(8'hC7);
    exp_q.push_back(8'h47);
    exp_q.push_back(8'hC7);
    wait_frames("t4", 4, 2000);
    wait_quiet("t4", 300);
    check_frames("t4");
    @(negedge clk); bus.blink_en = 1'b0;
    exp_q.push_back(8'h47);
    wait_frames("t4off", 1, 300);
    repeat (1000) @(negedge clk);
    check_frames("t4off");

    // T5: two refresh pulses while busy give exactly one extra frame
    pulse_refresh();
    repeat (10) @(negedge clk);
    check("t5_busy", bus.busy, 1);
    pulse_refresh();
    repeat (20) @(negedge clk);
    pulse_refresh();
    exp_q.push_back(8'h47);
    exp_q.push_back(8'h47);
    wait_frames("t5", 2, 400);
    wait_quiet("t5", 300);
    repeat (200) @(negedge clk);
    check_frames("t5");

    // T6: reset asserted mid SHIFT_HI with sr_data high
    pulse_refresh();
    begin
      int i = 0;
      while (!(dbg_state == SHIFT_HI && bus.sr_data) && i < 200) begin @(negedge clk); i++; end
    end
    check("t6_in_shift_hi", 32'(dbg_state), 32'(SHIFT_HI));
    #2 nrst = 1'b0;
    #1;
    check("t6_sr_clk", bus.sr_clk, 0);
    check("t6_sr_data", bus.sr_data, 0);
    check("t6_sr_latch", bus.sr_latch, 0);
    check("t6_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    got_q.delete();
    nrst = 1'b1;
    exp_q.push_back(8'h47);
    wait_frames("t6", 1, 200);
    wait_quiet("t6", 300);
    check_frames("t6");
    check("t6_busy_len", last_busy, 69);

    check("final_data_stable", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
